gray_counter: RTL and testbench
===============================

Name: gray_counter

Overview:
- Parametrised, registered binary/Gray counter: the sequential successor to the 4-bit combinational binary-to-Gray converter.
- Counts up or down in binary and presents both the binary value and its Gray encoding as glitch-free flop outputs.
- Intended as the pointer generator for async-FIFO write/read domains and rotary/position trackers.
- Supports synchronous load, a single-cycle wrap pulse, and a terminal-count indicator.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32.
- INIT, 0, reset value of the binary count (the Gray output resets to INIT's Gray encoding); must be less than 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- en  input  1  count enable
- up_dn  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous load strobe
- load_bin  input  WIDTH  binary value to load
- bin_out  output  WIDTH  registered binary count
- gray_out  output  WIDTH  registered Gray code of bin_out
- wrap  output  1  one-cycle pulse on modular wrap
- tc  output  1  registered terminal count: bin_out is all-ones when up_dn=1, or zero when up_dn=0 (combinational on the registered bin_out and the live up_dn)
- gray_err  output  1  Gray-step violation flag (see Optional Feature; tied 0 when the feature is compiled out)

Behaviour:
- All state updates on the rising clk edge.
- Reset (rst_n=0 at an edge): bin_out=INIT, gray_out=INIT^(INIT>>1), wrap=0, gray_err=0. Reset overrides load and en, including mid-count.
- Priority: rst_n > load > en.
- load=1: bin_next=load_bin. wrap=0 that cycle. en and up_dn are ignored.
- en=1, load=0, up_dn=1: bin_next=bin_out+1 modulo 2**WIDTH.
- en=1, load=0, up_dn=0: bin_next=bin_out-1 modulo 2**WIDTH.
- en=0, load=0: hold. wrap=0.
- gray_out is registered from bin_next^(bin_next>>1). It is never derived combinationally from bin_out, so the output has no decode glitches. gray_out and bin_out always update in the same cycle.
- Latency: one cycle from the en/load edge to the new bin_out/gray_out.
- wrap is registered and asserts for exactly one cycle after:
  - an increment from all-ones to 0, or
  - a decrement from 0 to all-ones.
  It never asserts on load, even if the loaded value equals the wrap target.
- Invariants:
  - Hamming distance between consecutive gray_out values is exactly 1 on every count step, in either direction.
  - It is 0 on hold.
  - It is unconstrained on load.
- A direction change (up_dn toggled while en=1) takes effect on the same edge. No bubble cycle.

Optional Feature:
- Macro: GRAY_COUNTER_STEP_CHECK_EN.
- Defined:
  - The block keeps a registered copy of the previous gray_out and a flag "last update was load".
  - On any cycle where the previous update was a count step and popcount(gray_out ^ prev_gray) != 1, gray_err is set.
  - gray_err is sticky until rst_n=0. Load and hold cycles are exempt.
- Undefined: gray_err is tied to 0 and the checker logic is not synthesised.

Test Plan:
- Reset: WIDTH=4, INIT=0, hold rst_n=0 for 2 cycles with en=1 -> bin_out=0000, gray_out=0000, wrap=0 throughout. Release -> first count at the next edge gives bin_out=0001, gray_out=0001.
- Full up sweep: WIDTH=4, en=1, up_dn=1 for 17 cycles from 0 ->
  - gray_out sequence: 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000.
  - wrap pulses exactly once, on the 1111->0000 step.
  - tc=1 only while bin_out=1111.
- Down wrap: count from 0 with up_dn=0 -> bin_out=1111, gray_out=1000, wrap=1 for one cycle. Next step -> bin_out=1110, gray_out=1001, wrap=0.
- Load priority: load=1, load_bin=1010, en=1, up_dn=1 in the same cycle -> bin_out=1010, gray_out=1111, wrap=0. Repeat with load_bin=0000 from 1111 -> wrap stays 0.
- Hold and direction change:
  - en=0 for 3 cycles at bin_out=0110 -> outputs unchanged.
  - Then en=1, up_dn alternating 1,0,1 -> bin_out 0111, 0110, 0111 and gray_out 0100, 0101, 0100.
- Reset mid-operation and width scaling:
  - WIDTH=8, INIT=8'h80, count up 5 steps, then rst_n=0 for 1 cycle -> bin_out=8'h80, gray_out=8'hC0.
  - With GRAY_COUNTER_STEP_CHECK_EN defined, a full 256-step sweep leaves gray_err=0.

Source files
------------

// File: rtl/gray_counter.sv
// gray_counter: registered up/down binary counter with a registered Gray-code
// output, synchronous load, one-cycle wrap pulse and terminal-count flag.
// Optional Gray-step checker is compiled in with GRAY_COUNTER_STEP_CHECK_EN.
module gray_counter #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap,
  output logic             tc,
  output logic             gray_err
);

  localparam logic [WIDTH-1:0] ALL_ONES  = '1;
  localparam logic [WIDTH-1:0] INIT_GRAY = INIT ^ (INIT >> 1);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;

  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_wrap_next;
  logic             w_step;

  // Count step happens only when enabled and not overridden by load.
  assign w_step = en & ~load;

  // Next binary value, its Gray encoding and the wrap condition.
  always_comb begin
    w_bin_next  = r_bin;
    w_wrap_next = 1'b0;
    if (load) begin
      w_bin_next = load_bin;
    end else if (en) begin
      if (up_dn) begin
        w_bin_next  = r_bin + WIDTH'(1);
        w_wrap_next = (r_bin == ALL_ONES);
      end else begin
        w_bin_next  = r_bin - WIDTH'(1);
        w_wrap_next = (r_bin == '0);
      end
    end
    w_gray_next = w_bin_next ^ (w_bin_next >> 1);
  end

  // Count, Gray and wrap registers; Gray is flopped from the next value so it
  // updates with the binary count and never decodes glitches from bin_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin  <= INIT;
      r_gray <= INIT_GRAY;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign bin_out  = r_bin;
  assign gray_out = r_gray;
  assign wrap     = r_wrap;
  // Terminal count follows the live direction input.
  assign tc       = up_dn ? (r_bin == ALL_ONES) : (r_bin == '0);

`ifdef GRAY_COUNTER_STEP_CHECK_EN
  logic [WIDTH-1:0] r_prev_gray;
  logic             r_last_step;
  logic             r_gray_err;
  logic [WIDTH-1:0] w_diff;
  logic             w_bad_step;

  // After a count step exactly one Gray bit may have changed (nonzero power of two).
  assign w_diff     = r_gray ^ r_prev_gray;
  assign w_bad_step = r_last_step &&
                      ((w_diff == '0) || ((w_diff & (w_diff - WIDTH'(1))) != '0));

  // Previous-Gray history, step flag and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev_gray <= INIT_GRAY;
      r_last_step <= 1'b0;
      r_gray_err  <= 1'b0;
    end else begin
      r_prev_gray <= r_gray;
      r_last_step <= w_step;
      if (w_bad_step) begin
        r_gray_err <= 1'b1;
      end
    end
  end

  assign gray_err = r_gray_err;
`else
  logic w_unused;
  assign w_unused = w_step;
  assign gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: directed scenarios plus random stimulus
// on a 4-bit (INIT=0) and an 8-bit (INIT=8'h80) instance against an
// arithmetic reference model.
module tb_gray_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, ld4, en4, up4;
  logic [3:0] lb4, bin4, gray4;
  logic       wrap4, tc4, err4;

  logic       rst8, ld8, en8, up8;
  logic [7:0] lb8, bin8, gray8;
  logic       wrap8, tc8, err8;

  gray_counter #(.WIDTH(4), .INIT(4'h0)) u_dut4 (
    .clk(clk), .rst_n(rst4), .en(en4), .up_dn(up4), .load(ld4), .load_bin(lb4),
    .bin_out(bin4), .gray_out(gray4), .wrap(wrap4), .tc(tc4), .gray_err(err4)
  );

  gray_counter #(.WIDTH(8), .INIT(8'h80)) u_dut8 (
    .clk(clk), .rst_n(rst8), .en(en8), .up_dn(up8), .load(ld8), .load_bin(lb8),
    .bin_out(bin8), .gray_out(gray8), .wrap(wrap8), .tc(tc8), .gray_err(err8)
  );

  int n_checks = 0;
  int n_errors = 0;
  int m4_bin = 0;
  int m8_bin = 128;
  bit m4_wrap = 1'b0;
  bit m8_wrap = 1'b0;
  logic [3:0] gseq [0:16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: counter value modulo 2**w with the stated priorities.
  function automatic void model_step(input int w, input int init, input bit rst,
                                     input bit ld, input bit en, input bit up,
                                     input int lb, input int b,
                                     output int nb, output bit wr);
    int m;
    m  = (1 << w) - 1;
    nb = b;
    wr = 1'b0;
    if (!rst) nb = init;
    else if (ld) nb = lb & m;
    else if (en && up) begin
      wr = (b == m);
      nb = (b + 1) & m;
    end else if (en) begin
      wr = (b == 0);
      nb = (b - 1) & m;
    end
  endfunction

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  // One clock: advance both models, then compare every output of both DUTs.
  task automatic tick();
    int nb;
    bit wr;
    model_step(4, 0, rst4, ld4, en4, up4, int'(lb4), m4_bin, nb, wr);
    m4_bin = nb; m4_wrap = wr;
    model_step(8, 128, rst8, ld8, en8, up8, int'(lb8), m8_bin, nb, wr);
    m8_bin = nb; m8_wrap = wr;
    @(posedge clk);
    #1;
    check("bin4",  32'(bin4),  32'(m4_bin));
    check("gray4", 32'(gray4), 32'(gray_of(m4_bin)));
    check("wrap4", 32'(wrap4), 32'(m4_wrap));
    check("tc4",   32'(tc4),   32'(up4 ? (m4_bin == 15) : (m4_bin == 0)));
    check("err4",  32'(err4),  32'(0));
    check("bin8",  32'(bin8),  32'(m8_bin));
    check("gray8", 32'(gray8), 32'(gray_of(m8_bin)));
    check("wrap8", 32'(wrap8), 32'(m8_wrap));
    check("tc8",   32'(tc8),   32'(up8 ? (m8_bin == 255) : (m8_bin == 0)));
    check("err8",  32'(err8),  32'(0));
  endtask

  initial begin
    int nwrap;
    gseq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
             4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    rst4 = 1'b0; ld4 = 1'b0; en4 = 1'b1; up4 = 1'b1; lb4 = 4'h0;
    rst8 = 1'b0; ld8 = 1'b0; en8 = 1'b0; up8 = 1'b1; lb8 = 8'h00;

    // Reset held with en=1.
    repeat (2) begin
      tick();
      check("rst_bin", 32'(bin4), 32'h0);
      check("rst_gray", 32'(gray4), 32'h0);
      check("rst_wrap", 32'(wrap4), 32'h0);
    end
    rst4 = 1'b1;
    tick();
    check("first_bin", 32'(bin4), 32'h1);
    check("first_gray", 32'(gray4), 32'h1);

    // Full up sweep from 0.
    ld4 = 1'b1; lb4 = 4'h0;
    tick();
    ld4 = 1'b0;
    check("sweep_g0", 32'(gray4), 32'(gseq[0]));
    nwrap = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("sweep_gseq", 32'(gray4), 32'(gseq[i]));
      nwrap += int'(wrap4);
    end
    check("sweep_wraps", 32'(nwrap), 32'd1);

    // Down wrap from 0.
    up4 = 1'b0;
    tick();
    check("dn_bin", 32'(bin4), 32'hF);
    check("dn_gray", 32'(gray4), 32'h8);
    check("dn_wrap", 32'(wrap4), 32'h1);
    tick();
    check("dn2_bin", 32'(bin4), 32'hE);
    check("dn2_gray", 32'(gray4), 32'h9);
    check("dn2_wrap", 32'(wrap4), 32'h0);

    // Load beats count; no wrap on load.
    ld4 = 1'b1; lb4 = 4'hA; en4 = 1'b1; up4 = 1'b1;
    tick();
    check("ld_bin", 32'(bin4), 32'hA);
    check("ld_gray", 32'(gray4), 32'hF);
    check("ld_wrap", 32'(wrap4), 32'h0);
    lb4 = 4'hF;
    tick();
    lb4 = 4'h0;
    tick();
    check("ld0_bin", 32'(bin4), 32'h0);
    check("ld0_wrap", 32'(wrap4), 32'h0);

    // Hold, then direction changes with no bubble.
    lb4 = 4'h6;
    tick();
    ld4 = 1'b0; en4 = 1'b0;
    repeat (3) tick();
    check("hold_bin", 32'(bin4), 32'h6);
    check("hold_gray", 32'(gray4), 32'h5);
    en4 = 1'b1; up4 = 1'b1;
    tick();
    check("dir1_bin", 32'(bin4), 32'h7);
    check("dir1_gray", 32'(gray4), 32'h4);
    up4 = 1'b0;
    tick();
    check("dir2_bin", 32'(bin4), 32'h6);
    check("dir2_gray", 32'(gray4), 32'h5);
    up4 = 1'b1;
    tick();
    check("dir3_bin", 32'(bin4), 32'h7);
    check("dir3_gray", 32'(gray4), 32'h4);

    // 8-bit instance: count, mid-count reset, full sweep.
    rst8 = 1'b1; en8 = 1'b1; up8 = 1'b1;
    repeat (5) tick();
    check("w8_cnt", 32'(bin8), 32'h85);
    rst8 = 1'b0;
    tick();
    check("w8_rst_bin", 32'(bin8), 32'h80);
    check("w8_rst_gray", 32'(gray8), 32'hC0);
    rst8 = 1'b1;
    repeat (256) tick();
    check("w8_sweep_bin", 32'(bin8), 32'h80);
    check("w8_sweep_err", 32'(err8), 32'h0);

    // Random stimulus on both instances.
    for (int i = 0; i < 600; i++) begin
      rst4 = ($urandom_range(0, 39) != 0);
      ld4  = ($urandom_range(0, 7) == 0);
      en4  = ($urandom_range(0, 3) != 0);
      up4  = 1'($urandom_range(0, 1));
      lb4  = 4'($urandom_range(0, 15));
      rst8 = ($urandom_range(0, 39) != 0);
      ld8  = ($urandom_range(0, 7) == 0);
      en8  = ($urandom_range(0, 3) != 0);
      up8  = 1'($urandom_range(0, 1));
      lb8  = 8'($urandom_range(0, 255));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
